// File: rtl/imem_boot_ctrl.sv
// Boot/load controller for the single-port instruction memory: streams a program in
// from address 0 while the core is stalled, pulses the core reset, then hands the port to fetch.
module imem_boot_ctrl #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [ADDR_W:0]   Word_Count,
  input  logic              Load_Valid,
  input  logic [DATA_W-1:0] Load_Data,
  output logic              Load_Ready,
  input  logic [ADDR_W-1:0] Cpu_Addr,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  output logic              Mem_WE,
  output logic              Cpu_Stall,
  output logic              Cpu_Rst,
  output logic              Done,
  output logic              Error
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] wr_ptr_q,  wr_ptr_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [TMO_W-1:0] tmo_q,     tmo_d;
  logic             error_q,   error_d;
  logic             done_q,    done_d;
  logic             stall_q,   stall_d;
  logic             ready_q,   ready_d;
  logic             cpu_rst_q, cpu_rst_d;

  logic start_legal_s;
  logic hs_s;

  // ready_q is high exactly while in LOAD, so the handshake needs no state decode
  assign start_legal_s = (Word_Count != CNT_W'(0)) && (Word_Count <= CNT_W'(DEPTH));
  assign hs_s          = Load_Valid & ready_q;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    error_d   = error_q;
    done_d    = done_q;
    stall_d   = stall_q;
    ready_d   = ready_q;
    cpu_rst_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (start_legal_s) begin
            state_d  = ST_LOAD;
            cnt_d    = Word_Count;
            wr_ptr_d = CNT_W'(0);
            tmo_d    = TMO_W'(0);
            error_d  = 1'b0;
            ready_d  = 1'b1;
            stall_d  = 1'b1;
            done_d   = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (hs_s) begin
          wr_ptr_d = wr_ptr_q + CNT_W'(1);
          tmo_d    = TMO_W'(0);
          if (wr_ptr_q == (cnt_q - CNT_W'(1))) begin
            state_d   = ST_RELEASE;
            ready_d   = 1'b0;
            cpu_rst_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          // Abandon the stalled load; memory keeps the partial image, IDLE points back at 0
          state_d  = ST_IDLE;
          error_d  = 1'b1;
          ready_d  = 1'b0;
          wr_ptr_d = CNT_W'(0);
          tmo_d    = TMO_W'(0);
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_RELEASE: begin
        state_d = ST_RUN;
        stall_d = 1'b0;
        done_d  = 1'b1;
      end

      ST_RUN: begin
        if (Start) begin
          if (start_legal_s) begin
            state_d  = ST_LOAD;
            cnt_d    = Word_Count;
            wr_ptr_d = CNT_W'(0);
            tmo_d    = TMO_W'(0);
            error_d  = 1'b0;
            ready_d  = 1'b1;
            stall_d  = 1'b1;
            done_d   = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end else begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        wr_ptr_d = CNT_W'(0);
        tmo_d    = TMO_W'(0);
        ready_d  = 1'b0;
        stall_d  = 1'b1;
        done_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= CNT_W'(0);
      cnt_q     <= CNT_W'(0);
      tmo_q     <= TMO_W'(0);
      error_q   <= 1'b0;
      done_q    <= 1'b0;
      stall_q   <= 1'b1;
      ready_q   <= 1'b0;
      cpu_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      error_q   <= error_d;
      done_q    <= done_d;
      stall_q   <= stall_d;
      ready_q   <= ready_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  // Address mux must be combinational so fetch and the load write see zero latency
  always_comb begin
    case (state_q)
      ST_RELEASE, ST_RUN: Mem_Addr = Cpu_Addr;
      ST_IDLE, ST_LOAD:   Mem_Addr = wr_ptr_q[ADDR_W-1:0];
      default:            Mem_Addr = wr_ptr_q[ADDR_W-1:0];
    endcase
  end

  assign Mem_WE     = hs_s;
  assign Mem_WData  = ready_q ? Load_Data : {DATA_W{1'b0}};
  assign Load_Ready = ready_q;
  assign Cpu_Stall  = stall_q;
  assign Cpu_Rst    = cpu_rst_q;
  assign Done       = done_q;
  assign Error      = error_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed, table-driven bench for imem_boot_ctrl (TIMEOUT overridden to 8),
// plus a hand-written full-depth reload sequence.
module tb_imem_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, lv;
  logic [10:0] wc;
  logic [15:0] ld;
  logic [9:0]  ca;
  logic        rdy, we, stall, crst, done, err;
  logic [9:0]  maddr;
  logic [15:0] wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_boot_ctrl #(.ADDR_W(10), .DATA_W(16), .DEPTH(1024), .TIMEOUT(8)) dut (
    .Clk(clk), .Rst(rst), .Start(start), .Word_Count(wc),
    .Load_Valid(lv), .Load_Data(ld), .Load_Ready(rdy), .Cpu_Addr(ca),
    .Mem_Addr(maddr), .Mem_WData(wdata), .Mem_WE(we),
    .Cpu_Stall(stall), .Cpu_Rst(crst), .Done(done), .Error(err)
  );

  typedef struct {
    logic        rst, start;
    logic [10:0] wc;
    logic        lv;
    logic [15:0] ld;
    logic [9:0]  ca;
    logic        e_rdy;
    logic [9:0]  e_addr;
    logic        e_we;
    logic [15:0] e_wd;
    logic        e_stall, e_crst, e_done, e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic [10:0] w, input logic v,
                     input logic [15:0] d, input logic [9:0] c, input logic e_rdy,
                     input logic [9:0] e_addr, input logic e_we, input logic e_stall,
                     input logic e_crst, input logic e_done, input logic e_err);
    vec_t x;
    x.rst = r; x.start = s; x.wc = w; x.lv = v; x.ld = d; x.ca = c;
    x.e_rdy = e_rdy; x.e_addr = e_addr; x.e_we = e_we; x.e_wd = d;
    x.e_stall = e_stall; x.e_crst = e_crst; x.e_done = e_done; x.e_err = e_err;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wc = 11'd0; lv = 1'b0; ld = 16'h0; ca = 10'h0;

    //   rst start wc  lv  ld  ca | rdy addr we stall crst done err
    // 1: reset, 4 back-to-back words, RELEASE, RUN with Cpu_Addr passthrough
    add(1'b1,1'b0,11'd0,   1'b0,16'h0000,10'h000, 1'b0,10'h000,1'b0, 1'b1,1'b0,1'b0,1'b0);
    add(1'b0,1'b1,11'd4,   1'b0,16'h0000,10'h000, 1'b0,10'h000,1'b0, 1'b1,1'b0,1'b0,1'b0);
    add(1'b0,1'b0,11'd0,   1'b1,16'h1111,10'h000, 1'b1,10'h000,1'b1, 1'b1,1'b0,1'b0,1'b0);
    add(1'b0,1'b0,11'd0,   1'b1,16'h2222,10'h000, 1'b1,10'h001,1'b1, 1'b1,1'b0,1'b0,1'b0);
    add(1'b0,1'b0,11'd0,   1'b1,16'h3333,10'h000, 1'b1,10'h002,1'b1, 1'b1,1'b0,1'b0,1'b0);
    add(1'b0,1'b0,11'd0,   1'b1,16'h4444,10'h000, 1'b1,10'h003,1'b1, 1'b1,1'b0,1'b0,1'b0);
    add(1'b0,1'b0,11'd0,   1'b0,16'h0000,10'h3FF, 1'b0,10'h3FF,1'b0, 1'b1,1'b1,1'b0,1'b0);
    add(1'b0,1'b0,11'd0,   1'b0,16'h0000,10'h3FF, 1'b0,10'h3FF,1'b0, 1'b0,1'b0,1'b1,1'b0);
    add(1'b0,1'b0,11'd0,   1'b1,16'h0000,10'h123, 1'b0,10'h123,1'b0, 1'b0,1'b0,1'b1,1'b0);
    // 2: reload from RUN, 3 words with gaps; Start in LOAD ignored
    add(1'b0,1'b1,11'd3,   1'b0,16'h0000,10'h005, 1'b0,10'h005,1'b0, 1'b0,1'b0,1'b1,1'b0);
    add(1'b0,1'b0,11'd0,   1'b1,16'hA001,10'h005, 1'b1,10'h000,1'b1, 1'b1,1'b0,1'b0,1'b0);
    add(1'b0,1'b0,11'd0,   1'b0,16'h0000,10'h005, 1'b1,10'h001,1'b0, 1'b1,1'b0,1'b0,1'b0);
    add(1'b0,1'b1,11'd0,   1'b0,16'h0000,10'h005, 1'b1,10'h001,1'b0, 1'b1,1'b0,1'b0,1'b0);
    add(1'b0,1'b0,11'd0,   1'b1,16'hA002,10'h005, 1'b1,10'h001,1'b1, 1'b1,1'b0,1'b0,1'b0);
    add(1'b0,1'b0,11'd0,   1'b0,16'h0000,10'h005, 1'b1,10'h002,1'b0, 1'b1,1'b0,1'b0,1'b0);
    add(1'b0,1'b0,11'd0,   1'b1,16'hA003,10'h005, 1'b1,10'h002,1'b1, 1'b1,1'b0,1'b0,1'b0);
    add(1'b0,1'b0,11'd0,   1'b0,16'h0000,10'h007, 1'b0,10'h007,1'b0, 1'b1,1'b1,1'b0,1'b0);
    add(1'b0,1'b0,11'd0,   1'b0,16'h0000,10'h007, 1'b0,10'h007,1'b0, 1'b0,1'b0,1'b1,1'b0);
    // 3: reset, illegal counts 0 and 1025 in IDLE, then legal count 1; illegal in RUN
    add(1'b1,1'b0,11'd0,   1'b0,16'h0000,10'h007, 1'b0,10'h007,1'b0, 1'b0,1'b0,1'b1,1'b0);
    add(1'b0,1'b1,11'd0,   1'b0,16'h0000,10'h000, 1'b0,10'h000,1'b0, 1'b1,1'b0,1'b0,1'b0);
    add(1'b0,1'b1,11'd1025,1'b1,16'h0000,10'h000, 1'b0,10'h000,1'b0, 1'b1,1'b0,1'b0,1'b1);
    add(1'b0,1'b0,11'd0,   1'b0,16'h0000,10'h000, 1'b0,10'h000,1'b0, 1'b1,1'b0,1'b0,1'b1);
    add(1'b0,1'b1,11'd1,   1'b0,16'h0000,10'h000, 1'b0,10'h000,1'b0, 1'b1,1'b0,1'b0,1'b1);
    add(1'b0,1'b0,11'd0,   1'b1,16'hBEEF,10'h000, 1'b1,10'h000,1'b1, 1'b1,1'b0,1'b0,1'b0);
    add(1'b0,1'b0,11'd0,   1'b0,16'h0000,10'h000, 1'b0,10'h000,1'b0, 1'b1,1'b1,1'b0,1'b0);
    add(1'b0,1'b0,11'd0,   1'b0,16'h0000,10'h2AA, 1'b0,10'h2AA,1'b0, 1'b0,1'b0,1'b1,1'b0);
    add(1'b0,1'b1,11'd1100,1'b0,16'h0000,10'h2AA, 1'b0,10'h2AA,1'b0, 1'b0,1'b0,1'b1,1'b0);
    add(1'b0,1'b0,11'd0,   1'b0,16'h0000,10'h2AA, 1'b0,10'h2AA,1'b0, 1'b0,1'b0,1'b1,1'b1);
    // 4: reload with 5, two words, then 8 idle cycles -> timeout abort to IDLE
    add(1'b0,1'b1,11'd5,   1'b0,16'h0000,10'h2AA, 1'b0,10'h2AA,1'b0, 1'b0,1'b0,1'b1,1'b1);
    add(1'b0,1'b0,11'd0,   1'b1,16'h5551,10'h2AA, 1'b1,10'h000,1'b1, 1'b1,1'b0,1'b0,1'b0);
    add(1'b0,1'b0,11'd0,   1'b1,16'h5552,10'h2AA, 1'b1,10'h001,1'b1, 1'b1,1'b0,1'b0,1'b0);
    for (int k = 0; k < 8; k++)
      add(1'b0,1'b0,11'd0, 1'b0,16'h0000,10'h2AA, 1'b1,10'h002,1'b0, 1'b1,1'b0,1'b0,1'b0);
    add(1'b0,1'b0,11'd0,   1'b1,16'h0000,10'h2AA, 1'b0,10'h000,1'b0, 1'b1,1'b0,1'b0,1'b1);
    // 5: reset after 2 of 4 words, then restart with 2 words from address 0
    add(1'b0,1'b1,11'd4,   1'b0,16'h0000,10'h000, 1'b0,10'h000,1'b0, 1'b1,1'b0,1'b0,1'b1);
    add(1'b0,1'b0,11'd0,   1'b1,16'h6661,10'h000, 1'b1,10'h000,1'b1, 1'b1,1'b0,1'b0,1'b0);
    add(1'b0,1'b0,11'd0,   1'b1,16'h6662,10'h000, 1'b1,10'h001,1'b1, 1'b1,1'b0,1'b0,1'b0);
    add(1'b1,1'b0,11'd0,   1'b0,16'h0000,10'h000, 1'b1,10'h002,1'b0, 1'b1,1'b0,1'b0,1'b0);
    add(1'b0,1'b0,11'd0,   1'b1,16'h0000,10'h000, 1'b0,10'h000,1'b0, 1'b1,1'b0,1'b0,1'b0);
    add(1'b0,1'b1,11'd2,   1'b0,16'h0000,10'h000, 1'b0,10'h000,1'b0, 1'b1,1'b0,1'b0,1'b0);
    add(1'b0,1'b0,11'd0,   1'b1,16'h7771,10'h000, 1'b1,10'h000,1'b1, 1'b1,1'b0,1'b0,1'b0);
    add(1'b0,1'b0,11'd0,   1'b1,16'h7772,10'h000, 1'b1,10'h001,1'b1, 1'b1,1'b0,1'b0,1'b0);
    add(1'b0,1'b0,11'd0,   1'b0,16'h0000,10'h010, 1'b0,10'h010,1'b0, 1'b1,1'b1,1'b0,1'b0);
    add(1'b0,1'b0,11'd0,   1'b0,16'h0000,10'h010, 1'b0,10'h010,1'b0, 1'b0,1'b0,1'b1,1'b0);

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; start = vecs[i].start; wc = vecs[i].wc;
      lv = vecs[i].lv; ld = vecs[i].ld; ca = vecs[i].ca;
      #1;
      chk("load_ready", i, {15'd0, rdy},   {15'd0, vecs[i].e_rdy});
      chk("mem_addr",   i, {6'd0, maddr},  {6'd0, vecs[i].e_addr});
      chk("mem_we",     i, {15'd0, we},    {15'd0, vecs[i].e_we});
      if (vecs[i].e_we) chk("mem_wdata", i, wdata, vecs[i].e_wd);
      chk("cpu_stall",  i, {15'd0, stall}, {15'd0, vecs[i].e_stall});
      chk("cpu_rst",    i, {15'd0, crst},  {15'd0, vecs[i].e_crst});
      chk("done",       i, {15'd0, done},  {15'd0, vecs[i].e_done});
      chk("error",      i, {15'd0, err},   {15'd0, vecs[i].e_err});
    end

    // 6: full-depth reload from RUN, addresses 0..1023 without wrap
    @(negedge clk);
    rst = 1'b0; start = 1'b1; wc = 11'd1024; lv = 1'b0; ca = 10'h010;
    #1;
    chk("full_start_done", 0, {15'd0, done}, 16'd1);
    for (int i = 0; i < 1024; i++) begin
      logic [9:0] exp_a;
      exp_a = 10'(i);
      @(negedge clk);
      start = 1'b0; lv = 1'b1; ld = 16'(i) ^ 16'hA5A5;
      #1;
      chk("full_addr",  i, {6'd0, maddr}, {6'd0, exp_a});
      chk("full_we",    i, {15'd0, we},   16'd1);
      chk("full_wdata", i, wdata, 16'(i) ^ 16'hA5A5);
      if (i == 0 || i == 1023) begin
        chk("full_done",  i, {15'd0, done},  16'd0);
        chk("full_stall", i, {15'd0, stall}, 16'd1);
      end
    end
    @(negedge clk);
    lv = 1'b0; ca = 10'h3FF;
    #1;
    chk("full_release_crst", 0, {15'd0, crst},  16'd1);
    chk("full_release_addr", 0, {6'd0, maddr},  16'h03FF);
    chk("full_release_we",   0, {15'd0, we},    16'd0);
    @(negedge clk);
    #1;
    chk("full_run_done",  0, {15'd0, done},  16'd1);
    chk("full_run_stall", 0, {15'd0, stall}, 16'd0);
    chk("full_run_crst",  0, {15'd0, crst},  16'd0);
    chk("full_run_err",   0, {15'd0, err},   16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
- Boot/load controller that owns the single port of the 16-bit instruction memory (1024 words, 10-bit address).
- Accepts a program stream over a valid/ready handshake and writes it sequentially from address 0, holding the CPU stalled during the load.
- Once the load completes, it hands the memory address port to the CPU fetch path.
- Sits between the external loader/host, the instruction memory and the single-cycle core's PC.

Parameters:
- ADDR_W, 10, instruction memory address width.
- DATA_W, 16, instruction width.
- DEPTH, 1024, number of memory words; maximum legal load count.
- TIMEOUT, 255, idle cycles allowed in LOAD without Load_Valid before abort.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  reset, synchronous, active-high.
- Start  input  1  one-cycle request to begin a (re)load; sampled in IDLE and RUN only.
- Word_Count  input  ADDR_W+1  number of words to load; latched on accepted Start.
- Load_Valid  input  1  loader has a word on Load_Data.
- Load_Data  input  DATA_W  instruction word.
- Load_Ready  output  1  controller accepts a word this cycle.
- Cpu_Addr  input  ADDR_W  fetch address from PC.
- Mem_Addr  output  ADDR_W  address to instruction memory.
- Mem_WData  output  DATA_W  write data to instruction memory.
- Mem_WE  output  1  memory write enable.
- Cpu_Stall  output  1  freezes PC and register writes.
- Cpu_Rst  output  1  one-cycle core reset pulse after a successful load.
- Done  output  1  program loaded, CPU running.
- Error  output  1  sticky error flag; cleared by the next accepted Start or by Rst.

Behaviour:
- States: IDLE, LOAD, RELEASE, RUN. State and all registers are updated on the rising edge of Clk.
- Rst has priority over all inputs, including mid-load.
  - Rst forces state=IDLE, wr_ptr=0, cnt=0, tmo=0, Error=0, Done=0.
  - Load_Ready=0, Mem_WE=0, Cpu_Rst=0, Cpu_Stall=1.
  - Memory contents are untouched.
- IDLE:
  - Outputs: Cpu_Stall=1, Mem_Addr=wr_ptr (0).
  - On Start with 1<=Word_Count<=DEPTH: latch cnt=Word_Count, set wr_ptr=0, tmo=0, Error=0, go to LOAD.
  - On Start with Word_Count=0 or >DEPTH: set Error=1, stay in IDLE.
- LOAD:
  - Outputs: Load_Ready=1, Cpu_Stall=1, Mem_Addr=wr_ptr, Mem_WData=Load_Data.
  - Mem_WE=Load_Valid&Load_Ready, combinational. The write lands in the same cycle as the handshake; zero latency.
  - On handshake: wr_ptr+=1, tmo=0.
  - On the handshake where wr_ptr==cnt-1: go to RELEASE. wr_ptr=cnt after this edge.
  - Without Load_Valid: tmo+=1. When tmo reaches TIMEOUT: set Error=1 and go to IDLE. Words already written stay in memory; Done stays 0.
  - Start is ignored in LOAD.
- RELEASE: lasts exactly one cycle.
  - Outputs: Cpu_Rst=1, Cpu_Stall=1, Load_Ready=0, Mem_Addr=Cpu_Addr.
  - Then go to RUN.
- RUN:
  - Outputs: Mem_Addr=Cpu_Addr, Mem_WE=0, Cpu_Stall=0, Done=1, Load_Ready=0.
  - On Start with a legal count: Done=0, Cpu_Stall=1 from the next cycle, go to LOAD (reload).
  - On Start with an illegal count: Error=1, stay in RUN.
- Load_Ready is 0 in every state except LOAD. Load_Valid outside LOAD has no effect.
- Count width:
  - Word_Count=DEPTH loads addresses 0..DEPTH-1.
  - wr_ptr is ADDR_W+1 bits, so it never wraps.
  - Mem_Addr uses the low ADDR_W bits.
- Reset during LOAD: the partial load is abandoned and wr_ptr=0; the next Start restarts from address 0.

Test Plan:
1. Rst, then Start with Word_Count=4 and words 0x1111,0x2222,0x3333,0x4444 valid back-to-back -> Mem_WE high 4 consecutive cycles at Mem_Addr 0..3. Then one RELEASE cycle with Cpu_Rst=1. Then Done=1, Cpu_Stall=0, and Mem_Addr follows Cpu_Addr (drive 0x3FF -> 0x3FF).
2. Word_Count=3 with Load_Valid gapped (1,0,0,1,0,1) -> exactly 3 writes at addresses 0,1,2; Mem_WE=0 on gap cycles; Done asserts 2 cycles after the 3rd handshake.
3. Start with Word_Count=0, then Start with 1025 -> Error=1, state stays IDLE, Load_Ready=0. A following Start with Word_Count=1 -> Error=0 and the load proceeds.
4. TIMEOUT=8, Word_Count=5, 2 words then no valid -> Error=1 after the 8th idle cycle, back in IDLE, Cpu_Stall=1, Done=0.
5. Rst asserted after 2 of 4 words -> next cycle IDLE, all outputs at reset values. Restart with Word_Count=2 -> writes begin again at address 0.
6. In RUN, Start with Word_Count=DEPTH and continuous valid -> Done drops, 1024 writes at addresses 0..1023 with no wrap, then RELEASE, then RUN again.
